// File: rtl/seg7_scan_driver.sv
// Time-multiplexed hex seven-segment driver with per-frame double buffering.
// Optional LEAD_ZERO_BLANK_EN blanks digits above the most significant nonzero digit.
module seg7_scan_driver #(
  parameter int N_DIGITS    = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic                  clk,
  input  logic                  btnC,
  input  logic [4*N_DIGITS-1:0] value,
  input  logic [N_DIGITS-1:0]   digit_en,
  input  logic [N_DIGITS-1:0]   dp_in,
  output logic [N_DIGITS-1:0]   an,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic                  frame_start
);
  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(N_DIGITS - 1);
  localparam logic INV = (ACTIVE_LOW != 0);

  logic [CW-1:0]         cnt;
  logic [IW-1:0]         idx;
  logic [4*N_DIGITS-1:0] shadow_value;
  logic [N_DIGITS-1:0]   shadow_en, shadow_dp;
  logic                  tick, wrap;
  logic [N_DIGITS-1:0]   show, an_d;
  logic [3:0]            sel_nib;
  logic                  sel_dp, lit;

  assign tick = (cnt == CNT_MAX);
  assign wrap = (idx == IDX_MAX);

  function automatic logic [6:0] seg_hex(input logic [3:0] h);
    case (h)
      4'h0: seg_hex = 7'b0111111;
      4'h1: seg_hex = 7'b0000110;
      4'h2: seg_hex = 7'b1011011;
      4'h3: seg_hex = 7'b1001111;
      4'h4: seg_hex = 7'b1100110;
      4'h5: seg_hex = 7'b1101101;
      4'h6: seg_hex = 7'b1111101;
      4'h7: seg_hex = 7'b0000111;
      4'h8: seg_hex = 7'b1111111;
      4'h9: seg_hex = 7'b1101111;
      4'hA: seg_hex = 7'b1110111;
      4'hB: seg_hex = 7'b1111100;
      4'hC: seg_hex = 7'b0111001;
      4'hD: seg_hex = 7'b1011110;
      4'hE: seg_hex = 7'b1111001;
      default: seg_hex = 7'b1110001;
    endcase
  endfunction

  always_ff @(posedge clk or posedge btnC) begin
    if (btnC) cnt <= '0;
    else      cnt <= tick ? '0 : cnt + 1'b1;
  end

  // Index starts at the last digit so the first tick wraps to 0 and loads the shadows.
  always_ff @(posedge clk or posedge btnC) begin
    if (btnC) begin
      idx          <= IDX_MAX;
      shadow_value <= '0;
      shadow_en    <= '0;
      shadow_dp    <= '0;
      frame_start  <= 1'b0;
    end else begin
      frame_start <= tick & wrap;
      if (tick) begin
        idx <= wrap ? '0 : idx + 1'b1;
        if (wrap) begin
          shadow_value <= value;
          shadow_en    <= digit_en;
          shadow_dp    <= dp_in;
        end
      end
    end
  end

`ifdef LEAD_ZERO_BLANK_EN
  always_comb begin
    show = '0;
    for (int i = 0; i < N_DIGITS; i++)
      show[i] = (i == 0) || ((shadow_value >> (4 * i)) != '0);
  end
`else
  always_comb show = '1;
`endif

  // An index with no matching digit leaves everything blank.
  always_comb begin
    an_d    = '0;
    sel_nib = '0;
    sel_dp  = 1'b0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (idx == IW'(i)) begin
        an_d[i] = shadow_en[i] & show[i];
        sel_nib = shadow_value[4*i +: 4];
        sel_dp  = shadow_dp[i];
      end
    end
    lit = |an_d;
  end

  always_ff @(posedge clk or posedge btnC) begin
    if (btnC) begin
      an  <= {N_DIGITS{INV}};
      seg <= {7{INV}};
      dp  <= INV;
    end else begin
      an  <= an_d ^ {N_DIGITS{INV}};
      seg <= (lit ? seg_hex(sel_nib) : 7'b0) ^ {7{INV}};
      dp  <= (lit & sel_dp) ^ INV;
    end
  end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: edge-count reference model plus directed literal frames.
module tb_seg7_scan_driver;
  localparam int N = 4, RD = 4;
  localparam logic [6:0] HEX [16] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                                     7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                                     7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
                                     7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001};
  logic clk = 0, btnC = 1;
  logic [15:0] value = 16'h1234;
  logic [3:0]  digit_en = 4'hF, dp_in = 4'h0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp, frame_start;
  logic [31:0] value8 = 32'h9A3F_0C75;
  logic [7:0]  en8 = 8'hFF, dp8 = 8'h5A, an8;
  logic [6:0]  seg8;
  logic        dpo8, fs8;
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  seg7_scan_driver #(.N_DIGITS(N), .REFRESH_DIV(RD), .ACTIVE_LOW(1)) dut (
    .clk(clk), .btnC(btnC), .value(value), .digit_en(digit_en), .dp_in(dp_in),
    .an(an), .seg(seg), .dp(dp), .frame_start(frame_start));

  seg7_scan_driver #(.N_DIGITS(8), .REFRESH_DIV(1), .ACTIVE_LOW(0)) dut8 (
    .clk(clk), .btnC(btnC), .value(value8), .digit_en(en8), .dp_in(dp8),
    .an(an8), .seg(seg8), .dp(dpo8), .frame_start(fs8));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: after edge j the selected digit is N-1 before the first tick, else (ticks-1) mod N.
  int k = 0;
  logic [15:0] sh_v = 0;
  logic [3:0]  sh_en = 0, sh_dp = 0;
  logic [3:0]  e_an = 4'hF;
  logic [6:0]  e_seg = 7'h7F;
  logic        e_dp = 1, e_fs = 0;

  function automatic int idx_after(input int j);
    return (j / RD == 0) ? N - 1 : ((j / RD) - 1) % N;
  endfunction

  always @(posedge clk or posedge btnC) begin
    if (btnC) begin
      k = 0; sh_v = 0; sh_en = 0; sh_dp = 0;
      e_an = 4'hF; e_seg = 7'h7F; e_dp = 1; e_fs = 0;
    end else begin
      int d;
      logic lit;
      k++;
      d = idx_after(k - 1);
`ifdef LEAD_ZERO_BLANK_EN
      lit = sh_en[d] && (d == 0 || (sh_v >> (4 * d)) != 16'h0);
`else
      lit = sh_en[d];
`endif
      e_an  = lit ? 4'(~(4'b0001 << d)) : 4'hF;
      e_seg = lit ? ~HEX[sh_v[4*d +: 4]] : 7'h7F;
      e_dp  = ~(lit & sh_dp[d]);
      e_fs  = (k % RD == 0) && (idx_after(k) == 0);
      if (e_fs) begin sh_v = value; sh_en = digit_en; sh_dp = dp_in; end
    end
  end

  always @(negedge clk) begin
    if (!btnC) begin
      chk("model_an", 32'(an), 32'(e_an));
      chk("model_seg", 32'(seg), 32'(e_seg));
      chk("model_dp", 32'(dp), 32'(e_dp));
      chk("model_fs", 32'(frame_start), 32'(e_fs));
    end
  end

  task automatic wait_fs(input int budget);
    int n = 0;
    do begin @(negedge clk); n++; end while (!frame_start && n < budget);
    chk("wait_frame_start", 32'(frame_start), 32'd1);
  endtask

  task automatic wait_an(input logic [3:0] target, input int budget);
    int n = 0;
    do begin @(negedge clk); n++; end while (an !== target && n < budget);
    chk("wait_an", 32'(an), 32'(target));
  endtask

  // Call at the negedge where frame_start is seen; slot s uses ans[4s+:4] / segs[7s+:7].
  task automatic frame_check(input string name, input logic [15:0] ans, input logic [27:0] segs);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i % 4 == 0) begin
        chk({name, "_an"}, 32'(an), 32'(ans[4*(i/4) +: 4]));
        chk({name, "_seg"}, 32'(seg), 32'(segs[7*(i/4) +: 7]));
      end else if (i % 4 == 3) begin
        chk({name, "_hold"}, 32'(an), 32'(ans[4*(i/4) +: 4]));
      end
      chk({name, "_fs_period"}, 32'(frame_start), 32'(i == 15));
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_an", 32'(an), 32'hF);
    chk("reset_seg", 32'(seg), 32'h7F);
    chk("reset_an8", 32'(an8), 32'h0);
    #2 btnC = 0;

    // Single-cycle slots on the 8-digit, high-true instance.
    for (int t = 1; t <= 40; t++) begin
      @(negedge clk);
      chk("n8_fs", 32'(fs8), 32'(t % 8 == 1));
      if (t == 1) begin
        chk("n8_blank_an", 32'(an8), 32'h0);
        chk("n8_blank_seg", 32'(seg8), 32'h0);
      end else begin
        chk("n8_an", 32'(an8), 32'(8'b1 << ((t - 2) % 8)));
        chk("n8_onehot", 32'($onehot(an8)), 32'd1);
        chk("n8_seg", 32'(seg8), 32'(HEX[value8[4*((t-2)%8) +: 4]]));
        chk("n8_dp", 32'(dpo8), 32'(dp8[(t - 2) % 8]));
      end
    end

    wait_fs(40);
    frame_check("f1234", {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001});

    wait_an(4'b1011, 40);
    value = 16'hABCD;
    wait_an(4'b0111, 20);
    chk("old_digit3", 32'(seg), 32'b1111001);
    wait_fs(40);
    frame_check("fABCD", {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                {7'b0001000, 7'b0000011, 7'b1000110, 7'b0100001});

    digit_en = 4'b0101;
    wait_fs(40);
    frame_check("fen0101", {4'b1111, 4'b1011, 4'b1111, 4'b1110},
                {7'b1111111, 7'b0000011, 7'b1111111, 7'b0100001});

    digit_en = 4'hF;
    value = 16'h0070;
    wait_fs(40);
`ifdef LEAD_ZERO_BLANK_EN
    frame_check("f0070", {4'b1111, 4'b1111, 4'b1101, 4'b1110},
                {7'b1111111, 7'b1111111, 7'b1111000, 7'b1000000});
    value = 16'h0000;
    wait_fs(40);
    frame_check("f0000", {4'b1111, 4'b1111, 4'b1111, 4'b1110},
                {7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000});
`else
    frame_check("f0070", {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                {7'b1000000, 7'b1000000, 7'b1111000, 7'b1000000});
`endif

    // Asynchronous reset mid-scan, checked before any clock edge.
    value = 16'h1234;
    wait_an(4'b1101, 40);
    #1 btnC = 1;
    #2;
    chk("async_an", 32'(an), 32'hF);
    chk("async_seg", 32'(seg), 32'h7F);
    chk("async_dp", 32'(dp), 32'h1);
    chk("async_fs", 32'(frame_start), 32'h0);
    #8 btnC = 0;
    wait_fs(40);
    frame_check("frestart", {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001});

    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      if ($urandom_range(7) == 0) value = 16'($urandom);
      if ($urandom_range(15) == 0) digit_en = 4'($urandom);
      if ($urandom_range(15) == 0) dp_in = 4'($urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
